// File: rtl/mipi_csi_pkg.sv
// mipi_csi_pkg: shared CSI-2 packet constants, ECC parity masks and decoder state encoding
package mipi_csi_pkg;
  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;
  // Row i selects the header bits whose XOR forms parity bit P[i].
  localparam logic [23:0] ECC_MASK [6] = '{
    24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00
  };
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DRAIN} state_e;
endpackage

// File: rtl/mipi_csi_packet_decoder_if.sv
// mipi_csi_packet_decoder_if: lane-merged input stream plus decoded payload/strobe outputs
//   master: drives data_valid_i/data_i, observes the decoder outputs
//   slave : the decoder side
interface mipi_csi_packet_decoder_if;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic        output_valid_o;
  logic [31:0] output_o;
  logic        output_last_o;
  logic        frame_start_o;
  logic        frame_end_o;
  logic        line_start_o;
  logic        line_end_o;
  logic [15:0] word_count_o;
  logic        ecc_error_o;
  logic        packet_error_o;
  modport master (
    output data_valid_i, data_i,
    input  output_valid_o, output_o, output_last_o, frame_start_o, frame_end_o,
           line_start_o, line_end_o, word_count_o, ecc_error_o, packet_error_o
  );
  modport slave (
    input  data_valid_i, data_i,
    output output_valid_o, output_o, output_last_o, frame_start_o, frame_end_o,
           line_start_o, line_end_o, word_count_o, ecc_error_o, packet_error_o
  );
endinterface

// File: rtl/mipi_csi_ecc_check.sv
// mipi_csi_ecc_check: combinational CSI-2 6-bit Hamming parity of a 24-bit packet header
//   hdr_i: {WC[15:0], DI[7:0]}
//   ecc_o: expected ECC byte bits [5:0]
module mipi_csi_ecc_check
  import mipi_csi_pkg::*;
(
  input  logic [23:0] hdr_i,
  output logic [5:0]  ecc_o
);
  for (genvar i = 0; i < 6; i++) begin : g_p
    assign ecc_o[i] = ^(hdr_i & ECC_MASK[i]);
  end
endmodule

// File: rtl/mipi_csi_packet_decoder.sv
// mipi_csi_packet_decoder: CSI-2 header parse/ECC check, forwards matching long-packet payload
//   clk_i, reset_i: byte clock, synchronous active-high reset
//   bus (slave)   : data_valid_i/data_i in; payload word, last, FS/FE/LS/LE strobes,
//                   word count, ECC and truncation error pulses out (all registered)
module mipi_csi_packet_decoder
  import mipi_csi_pkg::*;
#(
  parameter logic [5:0] ACCEPT_DT = DT_RAW10,
  parameter logic [1:0] ACCEPT_VC = 2'd0
) (
  input logic clk_i,
  input logic reset_i,
  mipi_csi_packet_decoder_if.slave bus
);
  state_e      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d, last_q, last_d;
  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic        ecc_err_q, ecc_err_d, perr_q, perr_d;
  logic [31:0] out_q, out_d;
  logic [15:0] wc_q, wc_d;
  logic [5:0]  ecc_calc, dt;
  logic [1:0]  vc;
  logic [15:0] wc;
  logic        valid, is_hdr, in_payload, hdr_ok, take_long, short_ok;
  assign valid      = bus.data_valid_i;
  assign dt         = bus.data_i[5:0];
  assign vc         = bus.data_i[7:6];
  assign wc         = bus.data_i[23:8];
  assign is_hdr     = state_q == S_IDLE && valid;
  assign in_payload = state_q == S_PAYLOAD;
  assign hdr_ok     = ecc_calc == bus.data_i[29:24] && vc == ACCEPT_VC;
  assign take_long  = hdr_ok && dt == ACCEPT_DT && wc != 16'd0;
  assign short_ok   = is_hdr && hdr_ok && dt < DT_LONG_MIN;
  mipi_csi_ecc_check u_ecc (
    .hdr_i (bus.data_i[23:0]),
    .ecc_o (ecc_calc)
  );
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      last_q      <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ls_q        <= 1'b0;
      le_q        <= 1'b0;
      wc_q        <= '0;
      ecc_err_q   <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      last_q      <= last_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      ls_q        <= ls_d;
      le_q        <= le_d;
      wc_q        <= wc_d;
      ecc_err_q   <= ecc_err_d;
      perr_q      <= perr_d;
    end
  end
  // Every header that is not an accepted long packet (bad ECC, short, foreign VC/DT, WC=0)
  // parks in DRAIN so the rest of its burst is swallowed.
  always_comb begin
    state_d = state_q == S_IDLE    ? (valid ? (take_long ? S_PAYLOAD : S_DRAIN) : S_IDLE)
            : state_q == S_PAYLOAD ? (!valid ? S_IDLE : cnt_q == 15'd1 ? S_DRAIN : S_PAYLOAD)
            : (valid ? S_DRAIN : S_IDLE);
    cnt_d   = is_hdr && take_long ? 15'((17'(wc) + 17'd3) >> 2)
            : in_payload && valid ? cnt_q - 15'd1 : cnt_q;
  end
  always_comb begin
    out_valid_d = in_payload && valid;
    out_d       = in_payload && valid ? bus.data_i : out_q;
    last_d      = in_payload && valid && cnt_q == 15'd1;
    fs_d        = short_ok && dt == DT_FS;
    fe_d        = short_ok && dt == DT_FE;
    ls_d        = short_ok && dt == DT_LS;
    le_d        = short_ok && dt == DT_LE;
    wc_d        = is_hdr && take_long ? wc : wc_q;
    ecc_err_d   = is_hdr && ecc_calc != bus.data_i[29:24];
    perr_d      = in_payload && !valid;
  end
  assign bus.output_valid_o = out_valid_q;
  assign bus.output_o       = out_q;
  assign bus.output_last_o  = last_q;
  assign bus.frame_start_o  = fs_q;
  assign bus.frame_end_o    = fe_q;
  assign bus.line_start_o   = ls_q;
  assign bus.line_end_o     = le_q;
  assign bus.word_count_o   = wc_q;
  assign bus.ecc_error_o    = ecc_err_q;
  assign bus.packet_error_o = perr_q;
endmodule

// File: tb/tb_mipi_csi_packet_decoder.sv
// tb_mipi_csi_packet_decoder: directed bursts checked every cycle against a burst-level model
module tb_mipi_csi_packet_decoder;
  localparam int MAXC = 256;
  // Column k: which parity bits header bit k contributes to.
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
    6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;
  mipi_csi_packet_decoder_if bus();
  mipi_csi_packet_decoder dut (.clk_i(clk), .reset_i(reset_i), .bus(bus));
  logic        in_v [MAXC];
  logic        in_r [MAXC];
  logic [31:0] in_d [MAXC];
  logic        e_v [MAXC], e_last [MAXC], e_fs [MAXC], e_fe [MAXC], e_ls [MAXC], e_le [MAXC];
  logic        e_ecc [MAXC], e_perr [MAXC];
  logic [31:0] e_d [MAXC];
  logic [15:0] e_wc [MAXC];
  int nc = 0, cur = 0, vectors = 0, errs = 0;
  bit run = 1'b0;
  function automatic logic [5:0] model_ecc(input logic [23:0] h);
    logic [5:0] r = '0;
    for (int k = 0; k < 24; k++) if (h[k]) r ^= ECC_COL[k];
    return r;
  endfunction
  function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc);
    return {2'b00, model_ecc({wc, di}), wc, di};
  endfunction
  task automatic push(input logic v, input logic [31:0] d, input logic r);
    in_v[nc] = v; in_d[nc] = d; in_r[nc] = r; nc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 32'h0, 1'b0);
  endtask
  task automatic words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) push(1'b1, base + 32'(i), 1'b0);
  endtask
  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %0h, want %0h", nm, c, act, exp);
    end
  endtask
  // Walk bursts: each burst's header decides what the following cycles must show.
  task automatic build_model();
    logic [15:0] hw = '0;
    logic [31:0] hd = '0;
    for (int c = 0; c < MAXC; c++) begin
      e_v[c] = 0; e_last[c] = 0; e_fs[c] = 0; e_fe[c] = 0; e_ls[c] = 0; e_le[c] = 0;
      e_ecc[c] = 0; e_perr[c] = 0; e_d[c] = '0; e_wc[c] = '0;
    end
    for (int c = 0; c < nc; c++) begin
      if (in_r[c]) begin
        hw = '0; hd = '0;
        e_v[c] = 0; e_last[c] = 0; e_perr[c] = 0;
      end else if (in_v[c] && (c == 0 || !in_v[c-1] || in_r[c-1])) begin
        int e, n;
        logic [31:0] h;
        e = c;
        while (e + 1 < nc && in_v[e+1] && !in_r[e+1]) e++;
        h = in_d[c];
        if (h[29:24] != model_ecc(h[23:0])) e_ecc[c] = 1;
        else if (h[7:6] == 2'd0) begin
          if (h[5:0] < 6'h10) begin
            e_fs[c] = h[5:0] == 6'h00; e_fe[c] = h[5:0] == 6'h01;
            e_ls[c] = h[5:0] == 6'h02; e_le[c] = h[5:0] == 6'h03;
          end else if (h[5:0] == 6'h2B && h[23:8] != 16'd0) begin
            hw = h[23:8];
            n = (int'(h[23:8]) + 3) / 4;
            for (int k = 1; k <= n && c + k <= e; k++) begin
              e_v[c+k] = 1; e_last[c+k] = (k == n);
            end
            if (e - c < n && e + 1 < nc && !in_r[e+1]) e_perr[e+1] = 1;
          end
        end
      end
      if (!in_r[c] && e_v[c]) hd = in_d[c];
      e_wc[c] = hw;
      e_d[c] = hd;
    end
  endtask
  always @(posedge clk) begin
    int c;
    if (run) begin
      c = cur;
      #1;
      chk("valid", c, 32'(bus.output_valid_o), 32'(e_v[c]));
      chk("data", c, bus.output_o, e_d[c]);
      chk("last", c, 32'(bus.output_last_o), 32'(e_last[c]));
      chk("fs", c, 32'(bus.frame_start_o), 32'(e_fs[c]));
      chk("fe", c, 32'(bus.frame_end_o), 32'(e_fe[c]));
      chk("ls", c, 32'(bus.line_start_o), 32'(e_ls[c]));
      chk("le", c, 32'(bus.line_end_o), 32'(e_le[c]));
      chk("wc", c, 32'(bus.word_count_o), 32'(e_wc[c]));
      chk("ecc_err", c, 32'(bus.ecc_error_o), 32'(e_ecc[c]));
      chk("pkt_err", c, 32'(bus.packet_error_o), 32'(e_perr[c]));
    end
  end
  initial begin
    bus.data_valid_i = 1'b0;
    bus.data_i = '0;
    chk("pin_ecc_raw10", -1, 32'(model_ecc(24'h00142B)), 32'h12);
    chk("pin_ecc_fs", -1, 32'(model_ecc(24'h000100)), 32'h1A);
    chk("pin_ecc_le", -1, 32'(model_ecc(24'h000003)), 32'h0C);
    push(1'b0, 32'h0, 1'b1); push(1'b0, 32'h0, 1'b1); push(1'b0, 32'h0, 1'b1);
    idle(2);
    push(1'b1, 32'h1200142B, 1'b0);
    push(1'b1, 32'h12345678, 1'b0); push(1'b1, 32'h00BCDEF0, 1'b0);
    push(1'b1, 32'h12005678, 1'b0); push(1'b1, 32'h9ABC00F0, 1'b0);
    push(1'b1, 32'hBBBBBB00, 1'b0); push(1'b1, 32'h0000ABCD, 1'b0);
    idle(2);
    push(1'b1, 32'h1A000100, 1'b0); idle(2);
    push(1'b1, 32'h0C000003, 1'b0); idle(2);
    push(1'b1, 32'h1200152B, 1'b0); words(5, 32'h55000000); push(1'b1, 32'h0000ABCD, 1'b0);
    idle(1);
    push(1'b1, hdr(8'h2B, 16'd8), 1'b0); push(1'b1, 32'hCAFEF00D, 1'b0);
    push(1'b1, 32'h01020304, 1'b0); push(1'b1, 32'h0000BEEF, 1'b0); idle(1);
    push(1'b1, hdr(8'h2A, 16'd20), 1'b0); words(6, 32'h2A000000); idle(1);
    push(1'b1, hdr(8'h6B, 16'd20), 1'b0); words(6, 32'h6B000000); idle(1);
    push(1'b1, hdr(8'h40, 16'd0), 1'b0); idle(1);
    push(1'b1, hdr(8'h05, 16'd0), 1'b0); idle(1);
    push(1'b1, hdr(8'h01, 16'd0), 1'b0); idle(1);
    push(1'b1, hdr(8'h02, 16'd9), 1'b0); idle(1);
    push(1'b1, hdr(8'h2B, 16'd20), 1'b0); words(3, 32'h77000000); idle(2);
    push(1'b1, hdr(8'h2B, 16'd20), 1'b0); words(2, 32'h88000000);
    push(1'b0, 32'h0, 1'b1); idle(1);
    push(1'b1, hdr(8'h2B, 16'd7), 1'b0); words(2, 32'h99000000); push(1'b1, 32'h00001234, 1'b0);
    idle(1);
    push(1'b1, hdr(8'h2B, 16'd0), 1'b0); words(1, 32'hEE000000); idle(1);
    push(1'b1, hdr(8'h2B, 16'd1), 1'b0); words(1, 32'h11000000); idle(1);
    push(1'b1, hdr(8'h2B, 16'd4), 1'b0); words(1, 32'h44000000); idle(1);
    push(1'b1, hdr(8'h2B, 16'd4), 1'b0); idle(2);
    push(1'b1, hdr(8'h2B, 16'd4) | 32'hC0000000, 1'b0); words(1, 32'hC0C0C0C0); idle(2);
    build_model();
    for (int c = 0; c < nc; c++) begin
      @(negedge clk);
      bus.data_valid_i = in_v[c];
      bus.data_i = in_d[c];
      reset_i = in_r[c];
      cur = c;
      run = 1'b1;
    end
    @(negedge clk);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mipi_csi_packet_decoder.md
# mipi_csi_packet_decoder

Packet-layer front end of the CSI-2 receive path: takes the 32-bit lane-merged byte stream from the lane aligner, parses and ECC-checks each packet header, and forwards only the long-packet payload words of the selected data type and virtual channel to `mipi_rx_raw10_depacker`. Short packets become single-cycle frame and line strobes. The 2-byte payload CRC and any tail bytes are discarded.

## Interface
- `ACCEPT_DT`, 6'h2B: long-packet data type forwarded (RAW10).
- `ACCEPT_VC`, 2'd0: virtual channel accepted. Packets on any other VC are ignored entirely, including short packets.
- `clk_i` in 1: byte clock; the only clock.
- `reset_i` in 1: reset, synchronous, active-high.
- `data_valid_i` in 1: high for every word of a packet burst and low between bursts.
- `data_i` in 32: packet bytes. Byte 0 is in [7:0], byte 3 is in [31:24].
- `output_valid_o` out 1: payload word valid. Drives the depacker's `data_valid_i`.
- `output_o` out 32: payload word. Same byte order as `data_i`.
- `output_last_o` out 1: marks the final payload word of a packet.
- `frame_start_o`, `frame_end_o`, `line_start_o`, `line_end_o` out 1 each: one-cycle strobes.
- `word_count_o` out 16: WC field of the last accepted header, held stable until the next accepted header.
- `ecc_error_o` out 1: one-cycle pulse for a header whose ECC mismatches.
- `packet_error_o` out 1: one-cycle pulse when a burst ends before its payload is complete.

## Operation
- The header is the first word with `data_valid_i`=1 while in IDLE.
  - DI = byte0: VC = [7:6], DT = [5:0].
  - WC = {byte2, byte1}.
  - ECC = byte3[5:0]; byte3[7:6] are ignored.
- ECC is the CSI-2 6-bit Hamming parity over the 24-bit {byte2, byte1, byte0}. Detection only, no correction.
  - On mismatch: pulse `ecc_error_o`, drop the packet, go to DRAIN.
- Short packet (DT < 6'h10, ECC good, VC match): decode DT 0x00/0x01/0x02/0x03 to FS/FE/LS/LE strobes. Other short DTs are silently ignored. Go to DRAIN.
- Long packet, ECC good, VC and DT match, WC ≠ 0:
  - latch `word_count_o`;
  - load the remaining-word counter with (WC+3)>>2 (15 bits, no overflow possible);
  - go to PAYLOAD.
- Long packet that is non-matching, or has WC = 0: go to DRAIN with no output.
- PAYLOAD: each valid word is forwarded and decrements the counter.
  - On the word where the counter equals 1: assert `output_last_o` and go to DRAIN.
  - When WC%4 ≠ 0, the unused upper bytes of the last word carry CRC/garbage and are forwarded unmodified.
- PAYLOAD with `data_valid_i`=0 before the last word: pulse `packet_error_o`, no `output_last_o`, go to IDLE.
- DRAIN: discard words (CRC, filler) while `data_valid_i`=1. Go to IDLE on the first cycle with `data_valid_i`=0.
  - If a single-word burst ends in the header cycle itself, the next cycle sees `data_valid_i`=0 and returns to IDLE.
- States: IDLE, PAYLOAD, DRAIN. Back-to-back bursts need at least one `data_valid_i`=0 cycle between them; that cycle is spent in DRAIN→IDLE.

## Timing
- All outputs are registered.
- Latency is 1 cycle: an input word at edge n appears on `output_o`/`output_valid_o` after edge n+1.
- Strobes and `ecc_error_o` assert the cycle after the header is sampled, for exactly one cycle.
- `packet_error_o` asserts the cycle after the first `data_valid_i`=0 sampled in PAYLOAD.
- No backpressure: the downstream stage must accept a word every cycle.
- Reset values: every output is 0, `word_count_o` = 0, state = IDLE, counter = 0.
- `reset_i` mid-packet takes effect at the next edge: outputs drop to 0 and the rest of the burst is ignored. The first `data_valid_i`=1 word seen in IDLE after reset is treated as a header, so the bench must deassert `data_valid_i` around reset.
- `output_o` holds its last value when `output_valid_o`=0. It is not zeroed.

## Structure
- Shared package `mipi_csi_pkg`:
  - DT constants `DT_FS`=0x00, `DT_FE`=0x01, `DT_LS`=0x02, `DT_LE`=0x03, `DT_RAW8`=0x2A, `DT_RAW10`=0x2B;
  - the long/short threshold 0x10;
  - the state encoding.
- Sub-module `mipi_csi_ecc_check`: combinational; input 24-bit header, output 6-bit parity. Reusable by the TX path.

## Test plan
- Header DI=0x2B, WC=0x0014, good ECC, then 5 payload words 0x12345678, 0x00BCDEF0, 0x12005678, 0x9ABC00F0, 0xBBBBBB00, then CRC word 0x0000ABCD, then `data_valid_i`=0 → `output_valid_o` high for exactly 5 cycles with those words, `output_last_o` on the 5th, `word_count_o`=0x0014, nothing forwarded for the CRC word.
- Short packet DI=0x00, WC=0x0001, good ECC, followed by DI=0x03 in a later burst → `frame_start_o` one pulse, then `line_end_o` one pulse, each one cycle after its header; `output_valid_o` stays 0.
- RAW10 header with byte1 bit 0 flipped (ECC stale) → `ecc_error_o` one pulse, zero output words, next good burst decoded normally.
- Header DI=0x2A (RAW8) or DI=0x6B (VC=1), WC=20 → no output, no error, DRAIN until `data_valid_i`=0.
- WC=20 but `data_valid_i` drops after 3 payload words → 3 outputs, no `output_last_o`, `packet_error_o` pulse one cycle after the drop.
- `reset_i` asserted for 1 cycle after payload word 2 → all outputs 0 next cycle; after `data_valid_i`=0 and a fresh good header, the packet is decoded fully with correct `output_last_o`.
